// File: rtl/route_compute_unit.sv
// route_compute_unit: per-port dimension-ordered route computation with packet-long route locking
module route_compute_unit #(
  parameter int NUM_IN     = 5,
  parameter int FLIT_W     = 34,
  parameter int X_W        = 4,
  parameter int Y_W        = 4,
  parameter int ROUTE_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [X_W+Y_W-1:0]       myaddr_i,
  input  logic [NUM_IN*FLIT_W-1:0] flit_i,
  input  logic [NUM_IN-1:0]        flit_valid_i,
  input  logic [NUM_IN-1:0]        flit_pop_i,
  output logic [NUM_IN*5-1:0]      route_o,
  output logic [NUM_IN-1:0]        route_valid_o,
  output logic [NUM_IN-1:0]        err_o
);
  typedef enum logic {IDLE, ROUTED} state_t;

  // One-hot bit order N,S,E,W,L from msb to lsb.
  function automatic logic [4:0] route_of(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy,
                                          input logic [X_W-1:0] mx, input logic [Y_W-1:0] my);
    logic [4:0] xr, yr;
    xr = dx > mx ? 5'b00100 : dx < mx ? 5'b00010 : 5'b00000;
    yr = dy > my ? 5'b10000 : dy < my ? 5'b01000 : 5'b00000;
    return ROUTE_MODE == 0 ? (xr != '0 ? xr : yr != '0 ? yr : 5'b00001)
                           : (yr != '0 ? yr : xr != '0 ? xr : 5'b00001);
  endfunction

  for (genvar g = 0; g < NUM_IN; g++) begin : g_port
    state_t     state_q, state_d;
    logic [4:0] route_q, route_d, dir;
    logic       err_q, err_d, hp_q, hp_d, is_head, is_tail, unused_bits;
    assign is_head     = flit_i[g*FLIT_W+FLIT_W-1];
    assign is_tail     = flit_i[g*FLIT_W+FLIT_W-2];
    assign unused_bits = ^flit_i[g*FLIT_W+X_W+Y_W +: FLIT_W-2-X_W-Y_W];
    assign dir = route_of(flit_i[g*FLIT_W+Y_W +: X_W], flit_i[g*FLIT_W +: Y_W],
                          myaddr_i[X_W+Y_W-1:Y_W], myaddr_i[Y_W-1:0]);
    // hp_q marks that the locked packet's head has left the queue, so a HEAD now at the front is a new packet.
    always_comb begin
      state_d = state_q;
      route_d = route_q;
      err_d   = err_q;
      hp_d    = hp_q;
      if (state_q == IDLE) begin
        if (flit_valid_i[g] && is_head) begin
          state_d = ROUTED;
          route_d = dir;
          hp_d    = 1'b0;
        end else if (flit_valid_i[g]) begin
          err_d = 1'b1;
        end
      end else begin
        err_d = err_q | (flit_valid_i[g] & is_head & hp_q);
        if (flit_pop_i[g]) begin
          hp_d = 1'b1;
          if (is_tail) begin
            state_d = IDLE;
            route_d = '0;
          end
        end
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        route_q <= '0;
        err_q   <= 1'b0;
        hp_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        route_q <= route_d;
        err_q   <= err_d;
        hp_q    <= hp_d;
      end
    end
    assign route_o[g*5 +: 5] = route_q;
    assign route_valid_o[g]  = state_q == ROUTED;
    assign err_o[g]          = err_q;
  end
endmodule

// File: tb/tb_route_compute_unit.sv
// tb_route_compute_unit: scoreboard bench running XY and YX instances side by side on the same stimulus
module tb_route_compute_unit;
  localparam int N  = 5;
  localparam int FW = 34;
  localparam logic [1:0] HEAD = 2'b10, BODY = 2'b00, TAIL = 2'b01, HT = 2'b11;
  localparam logic [4:0] RN = 5'b10000, RS = 5'b01000, RE = 5'b00100, RW = 5'b00010, RL = 5'b00001;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] myaddr = 8'h22;
  logic [N*FW-1:0] flit = '0;
  logic [N-1:0] valid = '0, pop = '0;
  logic [N*5-1:0] route_xy, route_yx;
  logic [N-1:0] rv_xy, rv_yx, err_xy, err_yx;
  int passed = 0, total = 0;

  typedef struct {int p; logic [4:0] exy; logic [4:0] eyx;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  route_compute_unit #(.ROUTE_MODE(0)) dut (
    .clk(clk), .rst(rst), .myaddr_i(myaddr), .flit_i(flit), .flit_valid_i(valid),
    .flit_pop_i(pop), .route_o(route_xy), .route_valid_o(rv_xy), .err_o(err_xy));
  route_compute_unit #(.ROUTE_MODE(1)) dut_yx (
    .clk(clk), .rst(rst), .myaddr_i(myaddr), .flit_i(flit), .flit_valid_i(valid),
    .flit_pop_i(pop), .route_o(route_yx), .route_valid_o(rv_yx), .err_o(err_yx));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic [1:0] ty, input logic [3:0] x, input logic [3:0] y);
    flit[p*FW +: FW] = {ty, 24'($urandom), x, y};
    valid[p] = 1'b1;
  endtask

  task automatic expect_route(input int p, input logic [4:0] exy, input logic [4:0] eyx);
    sb.push_back('{p, exy, eyx});
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({route_xy, route_yx} !== '0) $display("FAIL reset_route: got %h/%h want 0", route_xy, route_yx);
    else passed++;
    total++;
    if ({rv_xy, rv_yx, err_xy, err_yx} !== '0)
      $display("FAIL reset_status: got valid %b/%b err %b/%b want 0", rv_xy, rv_yx, err_xy, err_yx);
    else passed++;
    rst = 1'b0;
    while (sb.size() > 0) e = sb.pop_front();
  endtask

  task automatic test_head_tail(input int p, input logic [3:0] x, input logic [3:0] y,
                                input logic [4:0] exy, input logic [4:0] eyx);
    exp_t e;
    put(p, HT, x, y);
    expect_route(p, exy, eyx);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total += 2;
      if (rv_xy[e.p] !== 1'b1 || route_xy[e.p*5 +: 5] !== e.exy)
        $display("FAIL ht_xy p%0d dest {%0d,%0d}: valid=%b route=%b want valid=1 route=%b", e.p, x, y, rv_xy[e.p], route_xy[e.p*5 +: 5], e.exy);
      else passed++;
      if (rv_yx[e.p] !== 1'b1 || route_yx[e.p*5 +: 5] !== e.eyx)
        $display("FAIL ht_yx p%0d dest {%0d,%0d}: valid=%b route=%b want valid=1 route=%b", e.p, x, y, rv_yx[e.p], route_yx[e.p*5 +: 5], e.eyx);
      else passed++;
    end
    pop[p] = 1'b1;
    tick();
    pop[p] = 1'b0;
    valid[p] = 1'b0;
    total++;
    if (rv_xy[p] !== 1'b0 || rv_yx[p] !== 1'b0)
      $display("FAIL ht_release p%0d: valid=%b/%b want 0/0", p, rv_xy[p], rv_yx[p]);
    else passed++;
  endtask

  task automatic test_routes();
    myaddr = 8'h22;
    test_head_tail(4, 5, 0, RE, RS);
    test_head_tail(4, 2, 0, RS, RS);
    test_head_tail(4, 2, 2, RL, RL);
    test_head_tail(0, 5, 0, RE, RS);
    test_head_tail(0, 0, 2, RW, RW);
    test_head_tail(3, 0, 5, RW, RN);
  endtask

  task automatic test_packet();
    exp_t e;
    myaddr = 8'h22;
    put(1, HEAD, 2, 5);
    expect_route(1, RN, RN);
    tick();
    pop[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (rv_xy[e.p] !== 1'b1 || route_xy[e.p*5 +: 5] !== e.exy || rv_yx[e.p] !== 1'b1 || route_yx[e.p*5 +: 5] !== e.eyx)
          $display("FAIL pkt_locked cycle t+%0d: valid=%b/%b route=%b/%b want 1/1 %b/%b", i + 1, rv_xy[e.p], rv_yx[e.p], route_xy[e.p*5 +: 5], route_yx[e.p*5 +: 5], e.exy, e.eyx);
        else passed++;
      end
      if (i == 1) myaddr = 8'h77;
      if (i > 0) put(1, i == 3 ? TAIL : BODY, 2, 5);
      tick();
      if (i < 3) expect_route(1, RN, RN);
    end
    pop[1] = 1'b0;
    myaddr = 8'h22;
    total++;
    if (rv_xy[1] !== 1'b0 || rv_yx[1] !== 1'b0)
      $display("FAIL pkt_bubble t+5: valid=%b/%b want 0/0", rv_xy[1], rv_yx[1]);
    else passed++;
    test_head_tail(1, 0, 2, RW, RW);
  endtask

  task automatic test_all_ports();
    exp_t e;
    myaddr = 8'h22;
    put(0, HEAD, 5, 0); expect_route(0, RE, RS);
    put(1, HEAD, 0, 5); expect_route(1, RW, RN);
    put(2, HT,   2, 5); expect_route(2, RN, RN);
    put(3, HEAD, 2, 0); expect_route(3, RS, RS);
    put(4, HEAD, 2, 2); expect_route(4, RL, RL);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total += 2;
      if (rv_xy[e.p] !== 1'b1 || route_xy[e.p*5 +: 5] !== e.exy)
        $display("FAIL all_xy p%0d: valid=%b route=%b want valid=1 route=%b", e.p, rv_xy[e.p], route_xy[e.p*5 +: 5], e.exy);
      else passed++;
      if (rv_yx[e.p] !== 1'b1 || route_yx[e.p*5 +: 5] !== e.eyx)
        $display("FAIL all_yx p%0d: valid=%b route=%b want valid=1 route=%b", e.p, rv_yx[e.p], route_yx[e.p*5 +: 5], e.eyx);
      else passed++;
    end
    pop = '1;
    tick();
    expect_route(0, RE, RS);
    expect_route(1, RW, RN);
    expect_route(3, RS, RS);
    expect_route(4, RL, RL);
    total++;
    if (rv_xy !== 5'b11011 || rv_yx !== 5'b11011)
      $display("FAIL all_p2_release: valid=%b/%b want 11011/11011", rv_xy, rv_yx);
    else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (route_xy[e.p*5 +: 5] !== e.exy || route_yx[e.p*5 +: 5] !== e.eyx)
        $display("FAIL all_undisturbed p%0d: route=%b/%b want %b/%b", e.p, route_xy[e.p*5 +: 5], route_yx[e.p*5 +: 5], e.exy, e.eyx);
      else passed++;
    end
    valid[2] = 1'b0;
    for (int p = 0; p < N; p++) if (p != 2) put(p, TAIL, 0, 0);
    pop = 5'b11011;
    tick();
    pop = '0;
    valid = '0;
    total++;
    if ({rv_xy, rv_yx, err_xy, err_yx} !== '0)
      $display("FAIL all_release: valid=%b/%b err=%b/%b want 0", rv_xy, rv_yx, err_xy, err_yx);
    else passed++;
  endtask

  task automatic test_error();
    exp_t e;
    put(3, BODY, 1, 1);
    tick();
    valid[3] = 1'b0;
    total++;
    if (err_xy !== 5'b01000 || err_yx !== 5'b01000 || rv_xy[3] !== 1'b0 || rv_yx[3] !== 1'b0)
      $display("FAIL err_body: err=%b/%b valid3=%b/%b want 01000/01000 0/0", err_xy, err_yx, rv_xy[3], rv_yx[3]);
    else passed++;
    repeat (3) tick();
    total++;
    if (err_xy !== 5'b01000 || err_yx !== 5'b01000)
      $display("FAIL err_sticky: err=%b/%b want 01000/01000", err_xy, err_yx);
    else passed++;
    put(0, HEAD, 5, 0);
    tick();
    pop[0] = 1'b1;
    tick();
    pop[0] = 1'b0;
    put(0, HEAD, 0, 5);
    tick();
    expect_route(0, RE, RS);
    total++;
    if (err_xy !== 5'b01001 || err_yx !== 5'b01001)
      $display("FAIL err_head_routed: err=%b/%b want 01001/01001", err_xy, err_yx);
    else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rv_xy[e.p] !== 1'b1 || rv_yx[e.p] !== 1'b1 || route_xy[e.p*5 +: 5] !== e.exy || route_yx[e.p*5 +: 5] !== e.eyx)
        $display("FAIL err_route_kept p%0d: valid=%b/%b route=%b/%b want 1/1 %b/%b", e.p, rv_xy[e.p], rv_yx[e.p], route_xy[e.p*5 +: 5], route_yx[e.p*5 +: 5], e.exy, e.eyx);
      else passed++;
    end
    put(0, TAIL, 0, 0);
    pop[0] = 1'b1;
    tick();
    pop[0] = 1'b0;
    valid[0] = 1'b0;
    total++;
    if (rv_xy[0] !== 1'b0 || err_xy !== 5'b01001 || err_yx !== 5'b01001)
      $display("FAIL err_after_release: valid0=%b err=%b/%b want 0 01001/01001", rv_xy[0], err_xy, err_yx);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    put(0, HEAD, 5, 0); expect_route(0, RE, RS);
    put(2, HEAD, 2, 5); expect_route(2, RN, RN);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rv_xy[e.p] !== 1'b1 || rv_yx[e.p] !== 1'b1 || route_xy[e.p*5 +: 5] !== e.exy || route_yx[e.p*5 +: 5] !== e.eyx)
        $display("FAIL mid_routed p%0d: valid=%b/%b route=%b/%b want 1/1 %b/%b", e.p, rv_xy[e.p], rv_yx[e.p], route_xy[e.p*5 +: 5], route_yx[e.p*5 +: 5], e.exy, e.eyx);
      else passed++;
    end
    rst = 1'b1;
    tick();
    valid = '0;
    rst = 1'b0;
    total++;
    if ({route_xy, route_yx, rv_xy, rv_yx, err_xy, err_yx} !== '0)
      $display("FAIL mid_reset: route=%h/%h valid=%b/%b err=%b/%b want 0", route_xy, route_yx, rv_xy, rv_yx, err_xy, err_yx);
    else passed++;
    test_head_tail(2, 5, 0, RE, RS);
  endtask

  initial begin
    test_reset();
    test_routes();
    test_packet();
    test_all_ports();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
